// File: rtl/mem_port_sequencer.sv
// Initiator side of the shared instruction/data memory port: arbitrates IF fetches
// against MEM loads/stores, registers fetched words and extended load data.
module mem_port_sequencer #(
    parameter int ADDR_W       = 6,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic              if_valid_o,
    output logic [31:0]       if_instr_o,
    output logic              fetch_stall_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [2:0]        d_funct3_i,
    input  logic [ADDR_W+1:0] d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_ack_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              d_misalign_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [2:0]        mem_funct3_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_q, starve_d;
    logic          if_valid_q, d_rvalid_q, d_misalign_q;
    logic [31:0]   if_instr_q, d_rdata_q;

    logic grant_d_s, grant_f_s, misalign_s, aligned_d_s;

    function automatic logic [31:0] extend_load(input logic [2:0]  f3,
                                                input logic [1:0]  o,
                                                input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{o, 3'b000} +: 8];
        h = o[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extend_load = {{24{b[7]}}, b};
            3'b100:  extend_load = {24'h000000, b};
            3'b001:  extend_load = {{16{h[15]}}, h};
            3'b101:  extend_load = {16'h0000, h};
            default: extend_load = w;
        endcase
    endfunction

    // Arbitration, misalignment detection and memory-port steering.
    always_comb begin
        grant_d_s  = d_req_i && !(if_req_i && (starve_q == LIMIT_C));
        grant_f_s  = if_req_i && !grant_d_s;
        case (d_funct3_i)
            3'b001, 3'b101: misalign_s = d_addr_i[0];
            3'b010:         misalign_s = (d_addr_i[1:0] != 2'b00);
            default:        misalign_s = 1'b0;
        endcase
        aligned_d_s = grant_d_s && !misalign_s;

        if_ack_o      = grant_f_s;
        fetch_stall_o = if_req_i && !grant_f_s;
        d_ack_o       = grant_d_s;
        mem_read_o    = aligned_d_s && !d_we_i;
        mem_write_o   = aligned_d_s && d_we_i && rst_n;
        mem_wdata_o   = d_wdata_i;
        if (aligned_d_s) begin
            mem_addr_o   = d_addr_i[ADDR_W+1:2];
            mem_funct3_o = d_funct3_i;
        end else begin
            mem_addr_o   = if_addr_i;
            mem_funct3_o = 3'b000;
        end
    end

    // Fetch-starvation counter next state.
    always_comb begin
        if (grant_f_s || !if_req_i) begin
            starve_d = '0;
        end else if (grant_d_s && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Result registers: one-cycle pulses for valid/misalign, data words hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q     <= '0;
            if_valid_q   <= 1'b0;
            if_instr_q   <= 32'h0000_0000;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= 32'h0000_0000;
            d_misalign_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            if_valid_q   <= grant_f_s;
            d_rvalid_q   <= aligned_d_s && !d_we_i;
            d_misalign_q <= grant_d_s && misalign_s;
            if (grant_f_s) begin
                if_instr_q <= mem_rdata_i;
            end
            if (aligned_d_s && !d_we_i) begin
                d_rdata_q <= extend_load(d_funct3_i, d_addr_i[1:0], mem_rdata_i);
            end
        end
    end

    assign if_valid_o   = if_valid_q;
    assign if_instr_o   = if_instr_q;
    assign d_rvalid_o   = d_rvalid_q;
    assign d_rdata_o    = d_rdata_q;
    assign d_misalign_o = d_misalign_q;

endmodule
